word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-in, serial-out reader for the register datapath. It accepts an N-bit word through a valid/ready handshake and emits it one bit per accepted beat to a single-bit consumer, such as a chain of one-bit storage registers. It is the read/drain counterpart of the bitwise load path. It sits between a word-wide producer (register file or bus) and any bit-serial sink.

## Interface
- N, 64, word width in bits; legal range N ≥ 2
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; low clears all state immediately
- in_valid  input  1  producer presents a word on data_in
- in_ready  output  1  block can capture a word this cycle
- data_in  input  N  word to serialize
- out_ready  input  1  consumer accepts the current bit this cycle
- out_valid  output  1  data_out holds a valid bit
- data_out  output  1  current serial bit; 0 whenever out_valid = 0
- last  output  1  current bit is the final bit of the word; qualified by out_valid
- done  output  1  one-cycle pulse after the final bit is accepted
- busy  output  1  high in SHIFT or DONE

## Operation
- State: shift register sr[N-1:0]; bit counter cnt with width $clog2(N); FSM with states IDLE, SHIFT, DONE.
- Outputs in reset: in_ready = 0, out_valid = 0, data_out = 0, last = 0, done = 0, busy = 0; sr = 0, cnt = 0, state = IDLE.
- IDLE:
  - in_ready = 1.
  - If in_valid = 1 at an edge: sr ← data_in, cnt ← 0, go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - out_valid = 1; data_out = current head bit of sr (see Configuration).
  - last = (cnt == N-1).
  - On an edge with out_ready = 1: advance sr by one bit, filling the vacated end with 0, and increment cnt.
  - If out_ready = 1 and cnt == N-1: go to DONE instead of incrementing.
  - If out_ready = 0: hold sr, cnt and data_out unchanged. The bit must stay stable until accepted.
- DONE:
  - done = 1, in_ready = 0, out_valid = 0.
  - Return to IDLE unconditionally on the next edge.
- in_valid outside IDLE is ignored. data_in is sampled only at the capture edge.
- Reset asserted mid-word aborts the word. Remaining bits are discarded, the state is IDLE with all outputs at reset values, and no done pulse is produced.
- in_ready, out_valid, last, done and busy are decoded from registered state only, with no combinational path from any input. data_out is a direct function of sr and the state.

## Timing
- Capture edge k (in_valid & in_ready): first bit valid in cycle k+1.
- With out_ready held high: bit i is presented in cycle k+1+i; last bit in cycle k+N; done in cycle k+N+1; in_ready high again in cycle k+N+2.
- Sustained throughput is one word per N+2 cycles. Each out_ready-low cycle adds one cycle.
- Reset deassertion takes effect at the first rising clk edge after reset goes high. The block is in IDLE with in_ready = 1 from that point.

## Configuration
- SERIALIZER_MSB_FIRST_EN defined:
  - data_out = sr[N-1]; sr shifts left on each accepted beat.
  - Bit order is data_in[N-1] down to data_in[0].
- SERIALIZER_MSB_FIRST_EN not defined:
  - data_out = sr[0]; sr shifts right on each accepted beat.
  - Bit order is data_in[0] up to data_in[N-1].
- All handshake timing is identical in both builds.

## Test plan
- N = 8, LSB-first build, data_in = 8'hA5, out_ready held high:
  - data_out sequence 1,0,1,0,0,1,0,1 in cycles k+1..k+8.
  - last only in cycle k+8; done in k+9; in_ready in k+10.
- Same stimulus, MSB-first build: sequence 1,0,1,0,0,1,0,1 (0xA5 is a palindrome).
- Repeat with 8'h01 to confirm the order:
  - MSB-first build: seven 0s, then 1.
  - LSB-first build: 1, then seven 0s.
- Backpressure, data_in = 8'hF0: drop out_ready for 3 cycles at bit 2. data_out and cnt hold, and done arrives 3 cycles later than unstalled (k+12).
- in_valid held high with new data 8'h3C during SHIFT: ignored. The first word completes intact, and 8'h3C is captured only in the first cycle in_ready = 1 after done.
- Assert reset after bit 4 of 8'hFF:
  - All outputs drop to 0 immediately and asynchronously; no done pulse.
  - After release, a fresh 8'h81 serializes correctly from bit 0.

Source files
------------

// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer: word-wide producer side plus the
// bit-serial consumer side and status flags. The slave modport is the
// serializer itself; the master modport is whatever drives and drains it.
interface word_serializer_if #(
   parameter int N = 64
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] data_in;
   logic         out_ready;
   logic         out_valid;
   logic         data_out;
   logic         last;
   logic         done;
   logic         busy;

   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, data_out, last, done, busy
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, data_out, last, done, busy
   );
endinterface

// File: rtl/word_serializer.sv
// word_serializer: parallel-in, serial-out reader. Captures an N-bit word
// through a valid/ready handshake and drains it one bit per accepted beat.
// Bit order is selected at build time by SERIALIZER_MSB_FIRST_EN:
//   defined     -> data_in[N-1] first, shift register moves left
//   not defined -> data_in[0] first, shift register moves right
// Handshake timing is identical in both builds. Reset is asynchronous and
// active-low; a reset mid-word discards the word without a done pulse.
module word_serializer #(
   parameter int N = 64
) (
   input  logic            clk,
   input  logic            reset,
   word_serializer_if.slave bus
);

   localparam int              CW           = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0]   LAST_CNT     = CW'(N - 1);
   localparam logic [CW-1:0]   PRE_LAST_CNT = CW'(N - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e         state_q;
   logic [N-1:0]   sr_q;
   logic [N-1:0]   sr_shift_d;
   logic [CW-1:0]  cnt_q;
   logic           head_bit;
   logic           in_ready_q;
   logic           out_valid_q;
   logic           last_q;
   logic           done_q;
   logic           busy_q;

   // Shifted shift-register value and the bit currently at the output end.
   always_comb begin
`ifdef SERIALIZER_MSB_FIRST_EN
      sr_shift_d = {sr_q[N-2:0], 1'b0};
      head_bit   = sr_q[N-1];
`else
      sr_shift_d = {1'b0, sr_q[N-1:1]};
      head_bit   = sr_q[0];
`endif
   end

   // Sequencer: capture, shift one bit per accepted beat, pulse done, rearm.
   // Status flags are registered alongside the state so none of them has a
   // combinational path from an input.
   // NOTE: every register here uses <= so all updates see pre-edge values;
   // mixing in = would make results depend on statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_ready_q && bus.in_valid) begin
                  sr_q        <= bus.data_in;
                  cnt_q       <= '0;
                  state_q     <= SHIFT;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  last_q      <= 1'b0;
                  busy_q      <= 1'b1;
               end else begin
                  // First edge after reset release arms the input side.
                  in_ready_q  <= 1'b1;
               end
            end
            SHIFT: begin
               if (bus.out_ready) begin
                  sr_q <= sr_shift_d;
                  if (cnt_q == LAST_CNT) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b0;
                     last_q      <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     cnt_q  <= cnt_q + 1'b1;
                     last_q <= (cnt_q == PRE_LAST_CNT);
                  end
               end
            end
            DONE: begin
               state_q    <= IDLE;
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               in_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               last_q      <= 1'b0;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.last      = last_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.data_out  = (state_q == SHIFT) & head_bit;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer (N = 8). The stimulus process pushes
// the expected bit stream and the expected done cycle for every word it
// sends; a monitor process pops and compares whenever the DUT presents a bit
// or a done pulse. Bit order follows SERIALIZER_MSB_FIRST_EN.
module tb_word_serializer;

   localparam int N = 8;

   typedef struct packed {
      logic d;
      logic l;
   } exp_bit_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;

   exp_bit_t bit_q[$];
   int       done_q[$];

   word_serializer_if #(.N(N)) sig ();

   word_serializer #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
   endtask

   // Monitor: samples just after the falling edge, away from the active edge.
   always @(negedge clk) begin
      #1;
      if (sig.out_valid) begin
         if (bit_q.size() == 0) begin
            fail("bit_unexpected");
         end else begin
            check("data_out", int'(sig.data_out), int'(bit_q[0].d));
            check("last", int'(sig.last), int'(bit_q[0].l));
            if (sig.out_ready) void'(bit_q.pop_front());
         end
      end else begin
         check("data_out_idle", int'(sig.data_out), 0);
         check("last_idle", int'(sig.last), 0);
      end
      if (sig.done) begin
         if (done_q.size() == 0) fail("done_unexpected");
         else check("done_cycle", cyc, done_q.pop_front());
      end
   end

   function automatic logic exp_bit(input logic [N-1:0] w, input int i);
`ifdef SERIALIZER_MSB_FIRST_EN
      return w[N-1-i];
`else
      return w[i];
`endif
   endfunction

   // Send one word; out_ready is dropped for stall_len cycles starting when
   // bit stall_at is presented. With hold_next, in_valid stays high carrying
   // nxt for the whole word so it must be ignored until in_ready returns.
   task automatic send_word(input logic [N-1:0] w, input int stall_at,
                            input int stall_len, input bit hold_next,
                            input logic [N-1:0] nxt);
      int       k;
      int       t;
      exp_bit_t e;
      t = 0;
      while (!sig.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) fail("in_ready_timeout");
      sig.in_valid  = 1'b1;
      sig.data_in   = w;
      sig.out_ready = 1'b1;
      k = cyc;
      for (int i = 0; i < N; i++) begin
         e.d = exp_bit(w, i);
         e.l = (i == N - 1);
         bit_q.push_back(e);
      end
      done_q.push_back(k + N + 1 + stall_len);
      for (int c = 1; c <= N + stall_len + 1; c++) begin
         @(negedge clk);
         sig.in_valid  = hold_next;
         sig.data_in   = hold_next ? nxt : ~w;
         sig.out_ready = !(stall_len > 0 && c >= stall_at + 1 &&
                           c < stall_at + 1 + stall_len);
         check("in_ready_busy", int'(sig.in_ready), 0);
         check("busy_high", int'(sig.busy), 1);
      end
      @(negedge clk);
      sig.out_ready = 1'b1;
      check("in_ready_rearm", int'(sig.in_ready), 1);
      check("busy_low", int'(sig.busy), 0);
   endtask

   initial begin
      exp_bit_t e;
      checks        = 0;
      errors        = 0;
      cyc           = 0;
      reset         = 1'b0;
      sig.in_valid  = 1'b0;
      sig.data_in   = '0;
      sig.out_ready = 1'b0;

      #2;
      check("rst_in_ready", int'(sig.in_ready), 0);
      check("rst_out_valid", int'(sig.out_valid), 0);
      check("rst_data_out", int'(sig.data_out), 0);
      check("rst_done", int'(sig.done), 0);
      check("rst_busy", int'(sig.busy), 0);

      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_release_in_ready", int'(sig.in_ready), 1);

      send_word(8'hA5, 0, 0, 1'b0, 8'h00);
      send_word(8'h01, 0, 0, 1'b0, 8'h00);
      send_word(8'hF0, 2, 3, 1'b0, 8'h00);
      send_word(8'h96, 0, 0, 1'b1, 8'h3C);
      send_word(8'h3C, 0, 0, 1'b0, 8'h00);

      // Mid-word reset: start 8'hFF, abort while bit 4 is presented.
      while (!sig.in_ready) @(negedge clk);
      sig.in_valid  = 1'b1;
      sig.data_in   = 8'hFF;
      sig.out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         e.d = exp_bit(8'hFF, i);
         e.l = (i == N - 1);
         bit_q.push_back(e);
      end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         sig.in_valid = 1'b0;
      end
      #3;
      reset = 1'b0;
      #1;
      check("abort_out_valid", int'(sig.out_valid), 0);
      check("abort_data_out", int'(sig.data_out), 0);
      check("abort_last", int'(sig.last), 0);
      check("abort_busy", int'(sig.busy), 0);
      check("abort_in_ready", int'(sig.in_ready), 0);
      check("abort_done", int'(sig.done), 0);
      bit_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_release_in_ready", int'(sig.in_ready), 1);
      send_word(8'h81, 0, 0, 1'b0, 8'h00);

      begin
         int t;
         t = 0;
         while ((bit_q.size() != 0 || done_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) fail("drain_timeout");
      end
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
